// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with saturating direction counters and stored targets.
// Combinational lookup, edge-applied update, a ptr-driven invalidate sweep, and saturating usage statistics.
module branch_predictor_bht #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] lookup_pc_i,
   input  logic            lookup_en_i,
   output logic            pred_hit_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_mispred_i,
   input  logic            inv_req_i,
   output logic            busy_o,
   output logic [31:0]     stat_lookups_o,
   output logic [31:0]     stat_mispred_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [IDX_W-1:0] PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};
   localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [31:0]      STAT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [31:0]        stat_lookups_q, stat_lookups_d;
   logic [31:0]        stat_mispred_q, stat_mispred_d;

   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic [CNT_W-1:0]   cnt_q    [ENTRIES];

   logic [IDX_W-1:0]   lk_idx_s;
   logic [TAG_W-1:0]   lk_tag_s;
   logic [IDX_W-1:0]   upd_idx_s;
   logic [TAG_W-1:0]   upd_tag_s;
   logic               upd_hit_s;
   logic               upd_act_s;
   logic               cnt_we_s;
   logic               tgt_we_s;
   logic               alloc_s;
   logic [CNT_W-1:0]   cnt_new_s;
   logic               unused_s;

   assign lk_idx_s  = lookup_pc_i[IDX_W+1:2];
   assign lk_tag_s  = lookup_pc_i[XLEN-1:IDX_W+2];
   assign upd_idx_s = upd_pc_i[IDX_W+1:2];
   assign upd_tag_s = upd_pc_i[XLEN-1:IDX_W+2];
   assign unused_s  = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

   assign busy_o         = (state_q == ST_SWEEP);
   assign stat_lookups_o = stat_lookups_q;
   assign stat_mispred_o = stat_mispred_q;

   // Lookup reads registered table state only, so a same-cycle update is not bypassed.
   always_comb begin
      pred_hit_o    = 1'b0;
      pred_taken_o  = 1'b0;
      pred_target_o = lookup_pc_i + PC_STEP;
      if (valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s) && (state_q == ST_IDLE)) begin
         pred_hit_o   = 1'b1;
         pred_taken_o = cnt_q[lk_idx_s][CNT_W-1];
         if (cnt_q[lk_idx_s][CNT_W-1]) begin
            pred_target_o = target_q[lk_idx_s];
         end else begin
            pred_target_o = lookup_pc_i + PC_STEP;
         end
      end else begin
         pred_hit_o = 1'b0;
      end
   end

   assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
   assign upd_act_s = upd_valid_i && (state_q == ST_IDLE);

   // Update decode: train on a hit, allocate only on a taken miss, drop a not-taken miss.
   always_comb begin
      cnt_we_s  = 1'b0;
      tgt_we_s  = 1'b0;
      alloc_s   = 1'b0;
      cnt_new_s = cnt_q[upd_idx_s];
      if (upd_act_s) begin
         if (upd_hit_s) begin
            cnt_we_s = 1'b1;
            if (upd_taken_i) begin
               tgt_we_s = 1'b1;
               if (cnt_q[upd_idx_s] == CNT_MAX) begin
                  cnt_new_s = CNT_MAX;
               end else begin
                  cnt_new_s = cnt_q[upd_idx_s] + CNT_ONE;
               end
            end else begin
               tgt_we_s = 1'b0;
               if (cnt_q[upd_idx_s] == CNT_ZERO) begin
                  cnt_new_s = CNT_ZERO;
               end else begin
                  cnt_new_s = cnt_q[upd_idx_s] - CNT_ONE;
               end
            end
         end else if (upd_taken_i) begin
            alloc_s   = 1'b1;
            cnt_we_s  = 1'b1;
            tgt_we_s  = 1'b1;
            cnt_new_s = CNT_WEAK;
         end else begin
            cnt_we_s = 1'b0;
         end
      end else begin
         cnt_we_s = 1'b0;
      end
   end

   // Sweep FSM and valid-bit next state.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (inv_req_i) begin
               state_d = ST_SWEEP;
               ptr_d   = {IDX_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
            if (alloc_s) begin
               valid_d[upd_idx_s] = 1'b1;
            end else begin
               valid_d = valid_q;
            end
         end
         ST_SWEEP: begin
            valid_d[ptr_q] = 1'b0;
            ptr_d          = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SWEEP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Statistics keep counting through a sweep and stick at all-ones.
   always_comb begin
      stat_lookups_d = stat_lookups_q;
      stat_mispred_d = stat_mispred_q;
      if (lookup_en_i && (stat_lookups_q != STAT_MAX)) begin
         stat_lookups_d = stat_lookups_q + 32'd1;
      end else begin
         stat_lookups_d = stat_lookups_q;
      end
      if (upd_valid_i && upd_mispred_i && (stat_mispred_q != STAT_MAX)) begin
         stat_mispred_d = stat_mispred_q + 32'd1;
      end else begin
         stat_mispred_d = stat_mispred_q;
      end
   end

   // Control state: reset wins over sweep, updates and invalidate requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ptr_q          <= {IDX_W{1'b0}};
         valid_q        <= {ENTRIES{1'b0}};
         stat_lookups_q <= 32'd0;
         stat_mispred_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         valid_q        <= valid_d;
         stat_lookups_q <= stat_lookups_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   // Payload arrays carry no reset; they are only meaningful behind a set valid bit.
   always_ff @(posedge clk) begin
      if (!reset && cnt_we_s) begin
         cnt_q[upd_idx_s] <= cnt_new_s;
      end
      if (!reset && tgt_we_s) begin
         target_q[upd_idx_s] <= upd_target_i;
      end
      if (!reset && alloc_s) begin
         tag_q[upd_idx_s] <= upd_tag_s;
      end
   end

endmodule
